// File: rtl/ns2009_i2c_target.sv
// rtl/ns2009_i2c_target.sv - NS2009 touch controller I2C target: command write, 12-bit sample read
module ns2009_i2c_target #(
    parameter logic [6:0] ADDR7  = 7'h48,
    parameter logic [3:0] CMD_X  = 4'hC,
    parameter logic [3:0] CMD_Y  = 4'hD,
    parameter logic [3:0] CMD_Z1 = 4'hE
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [11:0] x_val,
    input  logic [11:0] y_val,
    input  logic [11:0] z1_val,
    output logic [7:0]  cmd_q,
    output logic        cmd_stb,
    output logic        rd_stb,
    output logic        busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
    } state_t;

    state_t      state, state_nxt;
    logic        scl_s1, scl_s2, scl_prev;
    logic        sda_s1, sda_s2, sda_prev;
    logic [7:0]  shreg, shreg_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic        sda_oe_nxt, busy_nxt, cmd_stb_nxt, rd_stb_nxt;
    logic [7:0]  cmd_q_nxt;
    logic [11:0] sample, sample_nxt;
    logic        byte_idx, byte_idx_nxt;

    logic        scl_rise, scl_fall, start_ev, stop_ev;
    logic [11:0] sel_val;
    logic [7:0]  rd_byte;
    logic [2:0]  bit_pos;

    assign scl_rise = scl_s2 & ~scl_prev;
    assign scl_fall = ~scl_s2 & scl_prev;
    assign start_ev = scl_s2 & sda_prev & ~sda_s2;
    assign stop_ev  = scl_s2 & ~sda_prev & sda_s2;

    always_comb begin
        sel_val = 12'h000;
        case (cmd_q[7:4])
            CMD_X:   sel_val = x_val;
            CMD_Y:   sel_val = y_val;
            CMD_Z1:  sel_val = z1_val;
            default: sel_val = 12'h000;
        endcase
    end

    assign rd_byte = byte_idx ? {sample[3:0], 4'h0} : sample[11:4];
    assign bit_pos = 3'd7 - bit_cnt[2:0];

    always_ff @(posedge clk) begin
        if (!resetb) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
            state    <= IDLE;
            shreg    <= 8'h00;
            bit_cnt  <= 4'd0;
            sda_oe   <= 1'b0;
            cmd_q    <= 8'h00;
            cmd_stb  <= 1'b0;
            rd_stb   <= 1'b0;
            busy     <= 1'b0;
            sample   <= 12'h000;
            byte_idx <= 1'b0;
        end else begin
            scl_s1   <= scl_in;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= sda_in;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            sda_oe   <= sda_oe_nxt;
            cmd_q    <= cmd_q_nxt;
            cmd_stb  <= cmd_stb_nxt;
            rd_stb   <= rd_stb_nxt;
            busy     <= busy_nxt;
            sample   <= sample_nxt;
            byte_idx <= byte_idx_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        sda_oe_nxt   = sda_oe;
        cmd_q_nxt    = cmd_q;
        cmd_stb_nxt  = 1'b0;
        rd_stb_nxt   = 1'b0;
        busy_nxt     = busy;
        sample_nxt   = sample;
        byte_idx_nxt = byte_idx;
        if (start_ev) begin
            state_nxt   = ADDR;
            sda_oe_nxt  = 1'b0;
            bit_cnt_nxt = 4'd0;
        end else if (stop_ev) begin
            state_nxt  = IDLE;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                ADDR, WR_DATA: begin
                    if (scl_rise) begin
                        shreg_nxt   = {shreg[6:0], sda_s2};
                        bit_cnt_nxt = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == ADDR) begin
                            if (shreg[7:1] == ADDR7) begin
                                state_nxt  = ADDR_ACK;
                                sda_oe_nxt = 1'b1;
                                busy_nxt   = 1'b1;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end else begin
                            cmd_q_nxt   = shreg;
                            cmd_stb_nxt = 1'b1;
                            sda_oe_nxt  = 1'b1;
                            state_nxt   = WR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (shreg[0]) begin
                            // The sample is frozen here for the whole read burst.
                            state_nxt    = RD_DATA;
                            sample_nxt   = sel_val;
                            rd_stb_nxt   = 1'b1;
                            byte_idx_nxt = 1'b0;
                            sda_oe_nxt   = ~sel_val[11];
                            bit_cnt_nxt  = 4'd1;
                        end else begin
                            state_nxt   = WR_DATA;
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = 4'd0;
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        state_nxt   = WR_DATA;
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 4'd0;
                    end
                end
                RD_DATA: begin
                    // bit_cnt counts bits already put on the wire for this byte.
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            state_nxt  = RD_ACK;
                            sda_oe_nxt = 1'b0;
                        end else begin
                            sda_oe_nxt  = ~rd_byte[bit_pos];
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && sda_s2) begin
                        state_nxt  = IGNORE;
                        sda_oe_nxt = 1'b0;
                    end else if (scl_fall) begin
                        state_nxt    = RD_DATA;
                        byte_idx_nxt = ~byte_idx;
                        sda_oe_nxt   = byte_idx ? ~sample[11] : ~sample[3];
                        bit_cnt_nxt  = 4'd1;
                    end
                end
                IGNORE: sda_oe_nxt = 1'b0;
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule
